// File: rtl/dsp_tap_buffer_pkg.sv
// dsp_tap_buffer_pkg: shared FSM state and width helpers for the tap buffer (optional DSP_TAP_BUFFER_SUM_EN sum width)
package dsp_tap_buffer_pkg;
  typedef enum logic {IDLE, SWEEP} state_t;
  function automatic int sel_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int sum_w(input int width, input int depth);
    return width + sel_w(depth) + 1;
  endfunction
endpackage

// File: rtl/dsp_tap_buffer_if.sv
// dsp_tap_buffer_if: sample bus and tap readout bundle; sum/sum_valid exist only with DSP_TAP_BUFFER_SUM_EN
interface dsp_tap_buffer_if import dsp_tap_buffer_pkg::*; #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8,
  parameter int SEL_W = sel_w(DEPTH),
  parameter int CNT_W = cnt_w(DEPTH),
  parameter int SUM_W = sum_w(WIDTH, DEPTH)
) ();
  logic en, we, start;
  logic [WIDTH-1:0] din, dout;
  logic [SEL_W-1:0] tap_sel;
  logic dout_valid, dout_last, busy, full, ovr;
  logic [CNT_W-1:0] fill_count;
`ifdef DSP_TAP_BUFFER_SUM_EN
  logic [SUM_W-1:0] sum;
  logic sum_valid;
`endif
  modport master (
    output en, we, din, tap_sel, start,
    input dout, dout_valid, dout_last, busy, fill_count, full, ovr
`ifdef DSP_TAP_BUFFER_SUM_EN
    , sum, sum_valid
`endif
  );
  modport slave (
    input en, we, din, tap_sel, start,
    output dout, dout_valid, dout_last, busy, fill_count, full, ovr
`ifdef DSP_TAP_BUFFER_SUM_EN
    , sum, sum_valid
`endif
  );
endinterface

// File: rtl/dsp_shift_store.sv
// dsp_shift_store: history shift register, newest at entry 0, with one combinational indexed read
module dsp_shift_store #(
  parameter logic RST_VAL = 1'b0,
  parameter int WIDTH = 24,
  parameter int DEPTH = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];
  // reset fills every entry; a push ages all entries by one and drops the oldest
  always_ff @(posedge clk) begin
    if (rst) mem <= '{default: {WIDTH{RST_VAL}}};
    else if (push) begin
      for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
      mem[0] <= din;
    end
  end
  assign rd_data = {1'b0, rd_sel} < (SEL_W + 1)'(DEPTH) ? mem[rd_sel] : '0;
endmodule

// File: rtl/dsp_tap_buffer.sv
// dsp_tap_buffer: tap history with random readback and newest-first sweep; DSP_TAP_BUFFER_SUM_EN adds a sweep sum
module dsp_tap_buffer import dsp_tap_buffer_pkg::*; #(
  parameter logic RST_VAL = 1'b0,
  parameter int WIDTH = 24,
  parameter int DEPTH = 8,
  parameter int SEL_W = sel_w(DEPTH),
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input logic clk,
  input logic rst,
  dsp_tap_buffer_if.slave bus
);
  state_t state, state_nx;
  logic [SEL_W-1:0] idx;
  logic [CNT_W-1:0] len, fill;
  logic [WIDTH-1:0] rd_data, dout;
  logic dout_valid, dout_last, ovr, busy, push, accept, last_beat;
`ifdef DSP_TAP_BUFFER_SUM_EN
  localparam int SUM_W = WIDTH + SEL_W + 1;
  logic [SUM_W-1:0] sum;
  logic sum_valid;
`endif
  assign busy = state == SWEEP;
  dsp_shift_store #(.RST_VAL(RST_VAL), .WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_store (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(bus.din),
    .rd_sel(busy ? idx : bus.tap_sel),
    .rd_data(rd_data)
  );
  // sweep control: accept a start only with data present, return to idle after the final beat
  always_comb begin
    push = bus.en & bus.we & !busy;
    accept = bus.en & bus.start & !busy & (fill != '0);
    last_beat = busy & (CNT_W'(idx) + CNT_W'(1) == len);
    state_nx = accept ? SWEEP : (bus.en & last_beat) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_nx;
  end
  // output registers, fill tracking and sweep index; everything freezes while en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= {WIDTH{RST_VAL}};
      dout_valid <= 1'b0;
      dout_last <= 1'b0;
      idx <= '0;
      len <= '0;
      fill <= '0;
      ovr <= 1'b0;
`ifdef DSP_TAP_BUFFER_SUM_EN
      sum <= '0;
      sum_valid <= 1'b0;
`endif
    end else if (bus.en) begin
      dout <= rd_data;
      dout_valid <= busy;
      dout_last <= last_beat;
      idx <= accept ? '0 : busy ? idx + SEL_W'(1) : idx;
      len <= accept ? fill : len;
      fill <= (push && fill != CNT_W'(DEPTH)) ? fill + CNT_W'(1) : fill;
      ovr <= accept ? 1'b0 : ovr | (busy & bus.we);
`ifdef DSP_TAP_BUFFER_SUM_EN
      sum <= accept ? '0 : busy ? sum + SUM_W'(rd_data) : sum;
      sum_valid <= last_beat;
`endif
    end
  end
  assign bus.dout = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.dout_last = dout_last;
  assign bus.busy = busy;
  assign bus.fill_count = fill;
  assign bus.full = fill == CNT_W'(DEPTH);
  assign bus.ovr = ovr;
`ifdef DSP_TAP_BUFFER_SUM_EN
  assign bus.sum = sum;
  assign bus.sum_valid = sum_valid;
`endif
endmodule

// File: tb/tb_dsp_tap_buffer.sv
// tb_dsp_tap_buffer: table vectors, corner sequences and random traffic against a beat-queue model (sum checked with DSP_TAP_BUFFER_SUM_EN)
module tb_dsp_tap_buffer;
  localparam int W = 24;
  localparam int D = 8;
  localparam int SW = 3;
  localparam logic RV = 1'b1;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  dsp_tap_buffer_if #(.WIDTH(W), .DEPTH(D)) bus ();
  dsp_tap_buffer #(.RST_VAL(RV), .WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  logic [W-1:0] hist [D];
  int m_fill;
  bit m_ovr, m_valid, m_last, m_sumv;
  logic [W-1:0] m_dout;
  logic [W+SW:0] m_sum;
  logic [W-1:0] beats [$];
  typedef struct {
    bit r, e, w;
    logic [W-1:0] d;
    logic [SW-1:0] s;
    bit st;
    logic [W-1:0] x_dout;
    bit x_valid, x_busy;
    int x_fill;
    bit x_ovr;
  } vec_t;
  vec_t tbl [$];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, act, exp);
    end
  endtask
  task automatic m_step();
    if (rst) begin
      foreach (hist[i]) hist[i] = ONES;
      m_fill = 0; m_ovr = 0; m_dout = ONES; m_valid = 0; m_last = 0; m_sum = 0; m_sumv = 0;
      beats.delete();
    end else if (bus.en) begin
      if (beats.size() != 0) begin
        if (bus.we) m_ovr = 1;
        m_dout = beats.pop_front();
        m_valid = 1;
        m_last = beats.size() == 0;
        m_sum = m_sum + m_dout;
        m_sumv = m_last;
      end else begin
        int l;
        l = m_fill;
        m_dout = int'(bus.tap_sel) < D ? hist[bus.tap_sel] : '0;
        m_valid = 0; m_last = 0; m_sumv = 0;
        if (bus.we) begin
          for (int i = D - 1; i > 0; i--) hist[i] = hist[i-1];
          hist[0] = bus.din;
          if (m_fill < D) m_fill++;
        end
        if (bus.start && l != 0) begin
          m_ovr = 0; m_sum = 0;
          for (int i = 0; i < l; i++) beats.push_back(hist[i]);
        end
      end
    end
  endtask
  task automatic cyc(input bit r, input bit e, input bit w, input logic [W-1:0] d, input logic [SW-1:0] s, input bit st);
    rst = r; bus.en = e; bus.we = w; bus.din = d; bus.tap_sel = s; bus.start = st;
    @(posedge clk);
    m_step();
    #1;
    chk("dout", bus.dout, m_dout);
    chk("dout_valid", bus.dout_valid, m_valid);
    chk("dout_last", bus.dout_last, m_last);
    chk("busy", bus.busy, beats.size() != 0);
    chk("fill_count", bus.fill_count, m_fill);
    chk("full", bus.full, m_fill == D);
    chk("ovr", bus.ovr, m_ovr);
`ifdef DSP_TAP_BUFFER_SUM_EN
    chk("sum", bus.sum, m_sum);
    chk("sum_valid", bus.sum_valid, m_sumv);
`endif
  endtask
  task automatic add(input bit r, input bit e, input bit w, input logic [W-1:0] d, input logic [SW-1:0] s, input bit st,
                     input logic [W-1:0] xd, input bit xv, input bit xb, input int xf, input bit xo);
    vec_t v;
    v.r = r; v.e = e; v.w = w; v.d = d; v.s = s; v.st = st;
    v.x_dout = xd; v.x_valid = xv; v.x_busy = xb; v.x_fill = xf; v.x_ovr = xo;
    tbl.push_back(v);
  endtask
  task automatic idle(input logic [SW-1:0] s);
    cyc(0, 1, 0, '0, s, 0);
  endtask
  initial begin
    logic [W-1:0] exp3 [3];
    int got;
    add(1, 1, 0, 0, 0, 0, ONES, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) add(0, 1, 1, W'(k), 0, 0, k == 1 ? ONES : W'(k - 1), 0, 0, k < D ? k : D, 0);
    add(0, 1, 0, 0, 0, 0, 24'h00000A, 0, 0, 8, 0);
    add(0, 1, 0, 0, 7, 0, 24'h000003, 0, 0, 8, 0);
    add(0, 0, 1, 24'h000055, 0, 1, 24'h000003, 0, 0, 8, 0);
    add(0, 1, 0, 0, 1, 0, 24'h000009, 0, 0, 8, 0);
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].e, tbl[i].w, tbl[i].d, tbl[i].s, tbl[i].st);
      chk("tbl_dout", bus.dout, tbl[i].x_dout);
      chk("tbl_valid", bus.dout_valid, tbl[i].x_valid);
      chk("tbl_busy", bus.busy, tbl[i].x_busy);
      chk("tbl_fill", bus.fill_count, tbl[i].x_fill);
      chk("tbl_full", bus.full, tbl[i].x_fill == D);
      chk("tbl_ovr", bus.ovr, tbl[i].x_ovr);
    end
    cyc(1, 1, 0, '0, 0, 0);
    cyc(0, 1, 1, 24'h111111, 0, 0);
    cyc(0, 1, 1, 24'h222222, 0, 0);
    cyc(0, 1, 1, 24'h333333, 0, 0);
    cyc(0, 1, 0, '0, 0, 1);
    chk("s1_busy", bus.busy, 1);
    chk("s1_valid0", bus.dout_valid, 0);
    exp3 = '{24'h333333, 24'h222222, 24'h111111};
    for (int i = 0; i < 3; i++) begin
      idle(0);
      chk("s1_beat", bus.dout, exp3[i]);
      chk("s1_valid", bus.dout_valid, 1);
      chk("s1_last", bus.dout_last, i == 2);
      chk("s1_busy_beat", bus.busy, i < 2);
    end
`ifdef DSP_TAP_BUFFER_SUM_EN
    chk("s1_sum", bus.sum, 28'h0666666);
    chk("s1_sum_valid", bus.sum_valid, 1);
`endif
    idle(0);
    chk("s1_after_valid", bus.dout_valid, 0);
    chk("s1_after_last", bus.dout_last, 0);
    cyc(0, 1, 1, 24'h444444, 0, 0);
    cyc(0, 1, 0, '0, 0, 1);
    cyc(0, 1, 1, 24'h123456, 0, 0);
    chk("s2_ovr", bus.ovr, 1);
    chk("s2_beat1", bus.dout, 24'h444444);
    for (int i = 0; i < 3; i++) idle(0);
    chk("s2_last", bus.dout_last, 1);
    idle(0);
    chk("s2_tap0", bus.dout, 24'h444444);
    idle(4);
    chk("s2_tap4", bus.dout, ONES);
    chk("s2_fill", bus.fill_count, 4);
    cyc(0, 1, 0, '0, 0, 1);
    chk("s2_ovr_clr", bus.ovr, 0);
    for (int i = 0; i < 10 && bus.busy; i++) idle(0);
    chk("s2_done", bus.busy, 0);
    cyc(0, 1, 0, '0, 0, 1);
    idle(0);
    chk("s3_beat1", bus.dout, 24'h444444);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, '0, 5, 0);
      chk("s3_hold_dout", bus.dout, 24'h444444);
      chk("s3_hold_valid", bus.dout_valid, 1);
      chk("s3_hold_busy", bus.busy, 1);
    end
    exp3 = '{24'h333333, 24'h222222, 24'h111111};
    got = 0;
    for (int i = 0; i < 10 && bus.busy; i++) begin
      idle(0);
      if (bus.dout_valid) begin
        if (got < 3) chk("s3_resume", bus.dout, exp3[got]);
        got++;
      end
    end
    chk("s3_count", got, 3);
    chk("s3_done", bus.busy, 0);
    idle(0);
    cyc(0, 1, 0, '0, 0, 1);
    idle(0);
    cyc(1, 1, 0, '0, 0, 0);
    chk("s4_busy", bus.busy, 0);
    chk("s4_valid", bus.dout_valid, 0);
    chk("s4_fill", bus.fill_count, 0);
    cyc(0, 1, 0, '0, 0, 1);
    chk("s4_start_ignored", bus.busy, 0);
    idle(0);
    chk("s4_no_beat", bus.dout_valid, 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)),
          W'($urandom), SW'($urandom_range(0, D - 1)), $urandom_range(0, 5) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
